// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: PC-source encodings,
// the nop word, the default boot address and the fetch FSM states.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_J   = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    CANCEL
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// SRAM-like instruction bus: one request outstanding, in-order responses.
interface fetch_unit_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/next_pc_gen.sv
// Decides whether the instruction held in ID transfers control and where to.
// Gating with ID_Valid and Stall is left to the caller.
module next_pc_gen
  import mips_pkg::*;
(
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_Instruction,
  input  logic [1:0]  ID_PCSrc,
  input  logic        ID_Branch,
  input  logic        ID_Zero,
  input  logic [31:0] ID_RegData,
  output logic        redirect_raw,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        unused_opcode;

  assign pc_plus4      = ID_PC + 32'd4;
  assign jump_target   = {pc_plus4[31:28], ID_Instruction[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{14{ID_Instruction[15]}}, ID_Instruction[15:0], 2'b00};
  assign unused_opcode = ^ID_Instruction[31:26];

  assign redirect_raw = (ID_PCSrc != PCSRC_SEQ) || (ID_Branch && ID_Zero);

  // Jump kinds outrank the conditional branch when both are flagged.
  always_comb begin
    target = branch_target;
    if (ID_PCSrc == PCSRC_J)
      target = jump_target;
    else if (ID_PCSrc[1])
      target = ID_RegData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM and IF/ID pipeline register. One bus request in flight;
// the word fetched behind a taken transfer is squashed (no delay slot).
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       bus,
  input  logic               Stall,
  input  logic               IF_Flush,
  input  logic [1:0]         ID_PCSrc,
  input  logic               ID_Branch,
  input  logic               ID_Zero,
  input  logic [31:0]        ID_RegData,
  output logic               ID_Valid,
  output logic [31:0]        ID_PC,
  output logic [31:0]        ID_Instruction
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  hold_buf;
  logic         redirect_raw;
  logic [31:0]  target;
  logic         redirect;
  logic         deliver;
  logic [31:0]  deliver_word;

  next_pc_gen u_next_pc_gen (
    .ID_PC          (ID_PC),
    .ID_Instruction (ID_Instruction),
    .ID_PCSrc       (ID_PCSrc),
    .ID_Branch      (ID_Branch),
    .ID_Zero        (ID_Zero),
    .ID_RegData     (ID_RegData),
    .redirect_raw   (redirect_raw),
    .target         (target)
  );

  assign redirect     = ID_Valid && !Stall && redirect_raw;
  assign deliver      = !Stall && !redirect &&
                        (((state == WAIT) && bus.inst_data_ok) || (state == HOLD));
  assign deliver_word = (state == HOLD) ? hold_buf : bus.inst_rdata;

  assign bus.inst_req  = (state == REQ) && !reset;
  assign bus.inst_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      hold_buf <= NOP;
    end else begin
      case (state)
        REQ: begin
          if (redirect) begin
            fetch_pc <= target;
            if (bus.inst_addr_ok) state <= CANCEL;
          end else if (bus.inst_addr_ok) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.inst_data_ok) begin
            if (redirect) begin
              fetch_pc <= target;
              state    <= REQ;
            end else if (Stall) begin
              hold_buf <= bus.inst_rdata;
              state    <= HOLD;
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
              state    <= REQ;
            end
          end else if (redirect) begin
            fetch_pc <= target;
            state    <= CANCEL;
          end
        end
        HOLD: begin
          if (redirect) begin
            fetch_pc <= target;
            state    <= REQ;
          end else if (!Stall) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= REQ;
          end
        end
        CANCEL: begin
          // The stale response still has to drain before a new request can go out.
          if (redirect) fetch_pc <= target;
          if (bus.inst_data_ok) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  // A bubble keeps ID_PC so that only the valid bit and the word change.
  always_ff @(posedge clk) begin
    if (reset) begin
      ID_Valid       <= 1'b0;
      ID_PC          <= 32'h0;
      ID_Instruction <= NOP;
    end else if (Stall) begin
      ID_Valid       <= ID_Valid;
    end else if (IF_Flush || redirect) begin
      ID_Valid       <= 1'b0;
      ID_Instruction <= NOP;
    end else if (deliver) begin
      ID_Valid       <= 1'b1;
      ID_PC          <= fetch_pc;
      ID_Instruction <= deliver_word;
    end else begin
      ID_Valid       <= 1'b0;
      ID_Instruction <= NOP;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-by-cycle directed vectors for fetch_unit: the bench plays both the
// instruction bus and the hazard/decode side; expected values are hand-derived.
module tb_fetch_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  pcsrc;
    logic        br;
    logic        zero;
    logic [31:0] regdata;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        IF_Flush;
  logic [1:0]  ID_PCSrc;
  logic        ID_Branch;
  logic        ID_Zero;
  logic [31:0] ID_RegData;
  logic        ID_Valid;
  logic [31:0] ID_PC;
  logic [31:0] ID_Instruction;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  fetch_unit_if inst_bus ();

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (inst_bus),
    .Stall          (Stall),
    .IF_Flush       (IF_Flush),
    .ID_PCSrc       (ID_PCSrc),
    .ID_Branch      (ID_Branch),
    .ID_Zero        (ID_Zero),
    .ID_RegData     (ID_RegData),
    .ID_Valid       (ID_Valid),
    .ID_PC          (ID_PC),
    .ID_Instruction (ID_Instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(
    input logic rst, input logic stall, input logic flush, input logic [1:0] pcsrc,
    input logic br, input logic zero, input logic [31:0] regdata,
    input logic aok, input logic dok, input logic [31:0] rdata,
    input logic e_req, input logic [31:0] e_addr, input logic e_valid,
    input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t r;
    r.rst = rst; r.stall = stall; r.flush = flush; r.pcsrc = pcsrc;
    r.br = br; r.zero = zero; r.regdata = regdata;
    r.aok = aok; r.dok = dok; r.rdata = rdata;
    r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid;
    r.e_pc = e_pc; r.e_instr = e_instr;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t s);
    reset                 = s.rst;
    Stall                 = s.stall;
    IF_Flush              = s.flush;
    ID_PCSrc              = s.pcsrc;
    ID_Branch             = s.br;
    ID_Zero               = s.zero;
    ID_RegData            = s.regdata;
    inst_bus.inst_addr_ok = s.aok;
    inst_bus.inst_data_ok = s.dok;
    inst_bus.inst_rdata   = s.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t s);
    checkOutput($sformatf("v%0d.inst_req", idx), {31'h0, inst_bus.inst_req}, {31'h0, s.e_req});
    checkOutput($sformatf("v%0d.inst_addr", idx), inst_bus.inst_addr, s.e_addr);
    checkOutput($sformatf("v%0d.ID_Valid", idx), {31'h0, ID_Valid}, {31'h0, s.e_valid});
    checkOutput($sformatf("v%0d.ID_PC", idx), ID_PC, s.e_pc);
    checkOutput($sformatf("v%0d.ID_Instruction", idx), ID_Instruction, s.e_instr);
  endtask

  initial begin
    // Fields: rst stall flush pcsrc br zero regdata aok dok rdata | req addr valid pc instr
    // Reset state, then zero-wait fetches from RESET_PC
    vecs.push_back(v(1,0,0,2'b00,0,0,32'h0,0,0,32'h0,                1,32'h8000_0000,0,32'h0,32'h0));
    vecs[0].e_req = 1'b0;
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0000,0,32'h0,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h2401_0001,        0,32'h8000_0000,0,32'h0,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0004,1,32'h8000_0000,32'h2401_0001));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h2402_0002,        0,32'h8000_0004,0,32'h8000_0000,32'h0));
    // Stall across data_ok: word parked in HOLD, released on first free edge
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0008,1,32'h8000_0004,32'h2402_0002));
    vecs.push_back(v(0,1,0,2'b00,0,0,32'h0,0,1,32'h2402_0005,        0,32'h8000_0008,0,32'h8000_0004,32'h0));
    vecs.push_back(v(0,1,0,2'b00,0,0,32'h0,0,0,32'h0,                0,32'h8000_0008,0,32'h8000_0004,32'h0));
    vecs.push_back(v(0,1,0,2'b00,0,0,32'h0,0,0,32'h0,                0,32'h8000_0008,0,32'h8000_0004,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,0,32'h0,                0,32'h8000_0008,0,32'h8000_0004,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_000C,1,32'h8000_0008,32'h2402_0005));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h2403_0003,        0,32'h8000_000C,0,32'h8000_0008,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0010,1,32'h8000_000C,32'h2403_0003));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h1000_FFFF,        0,32'h8000_0010,0,32'h8000_000C,32'h0));
    // Taken beq (imm -1) coincident with addr_ok: CANCEL drains the stale word
    vecs.push_back(v(0,0,0,2'b00,1,1,32'h0,1,0,32'h0,                1,32'h8000_0014,1,32'h8000_0010,32'h1000_FFFF));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'hDEAD_BEEF,        0,32'h8000_0010,0,32'h8000_0010,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0010,0,32'h8000_0010,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h0320_0008,        0,32'h8000_0010,0,32'h8000_0010,32'h0));
    // jr coincident with addr_ok
    vecs.push_back(v(0,0,0,2'b10,0,0,32'h8000_0200,1,0,32'h0,        1,32'h8000_0014,1,32'h8000_0010,32'h0320_0008));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'hBADC_0DE5,        0,32'h8000_0200,0,32'h8000_0010,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0200,0,32'h8000_0010,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h0320_0008,        0,32'h8000_0200,0,32'h8000_0010,32'h0));
    // jr while REQ is not yet accepted: address changes in place
    vecs.push_back(v(0,0,0,2'b10,0,0,32'hFFFF_FFFC,0,0,32'h0,        1,32'h8000_0204,1,32'h8000_0200,32'h0320_0008));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'hFFFF_FFFC,0,32'h8000_0200,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h0800_0040,        0,32'hFFFF_FFFC,0,32'h8000_0200,32'h0));
    // j at 0xFFFF_FFFC: sequential pc wraps to 0, target region from wrapped pc
    vecs.push_back(v(0,0,0,2'b01,0,0,32'h0,1,0,32'h0,                1,32'h0000_0000,1,32'hFFFF_FFFC,32'h0800_0040));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h1111_1111,        0,32'h0000_0100,0,32'hFFFF_FFFC,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h0000_0100,0,32'hFFFF_FFFC,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h2405_0005,        0,32'h0000_0100,0,32'hFFFF_FFFC,32'h0));
    // Stall holds a valid IF/ID into WAIT, then j redirects together with data_ok
    vecs.push_back(v(0,1,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h0000_0104,1,32'h0000_0100,32'h2405_0005));
    vecs.push_back(v(0,0,0,2'b01,0,0,32'h0,0,1,32'h2222_2222,        0,32'h0000_0104,1,32'h0000_0100,32'h2405_0005));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,0,32'h0,                1,32'h0014_0014,0,32'h0000_0100,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h0014_0014,0,32'h0000_0100,32'h0));
    // Reset while WAIT: request suppressed, refetch from RESET_PC
    vecs.push_back(v(1,0,0,2'b00,0,0,32'h0,0,0,32'h0,                0,32'h0014_0014,0,32'h0000_0100,32'h0));
    vecs.push_back(v(1,0,0,2'b00,0,0,32'h0,1,0,32'h0,                0,32'h8000_0000,0,32'h0,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0000,0,32'h0,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h2401_0001,        0,32'h8000_0000,0,32'h0,32'h0));
    // jr in WAIT without data_ok goes through CANCEL
    vecs.push_back(v(0,1,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0004,1,32'h8000_0000,32'h2401_0001));
    vecs.push_back(v(0,0,0,2'b10,0,0,32'h8000_0400,0,0,32'h0,        0,32'h8000_0004,1,32'h8000_0000,32'h2401_0001));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,0,32'h0,                0,32'h8000_0400,0,32'h8000_0000,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h3333_3333,        0,32'h8000_0400,0,32'h8000_0000,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0400,0,32'h8000_0000,32'h0));
    // IF_Flush bubbles the delivered word but fetch still advances
    vecs.push_back(v(0,0,1,2'b00,0,0,32'h0,0,1,32'h2402_0002,        0,32'h8000_0400,0,32'h8000_0000,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0404,0,32'h8000_0000,32'h0));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,1,32'h2402_0002,        0,32'h8000_0404,0,32'h8000_0000,32'h0));
    // Redirect out of HOLD drops the parked word
    vecs.push_back(v(0,1,0,2'b00,0,0,32'h0,1,0,32'h0,                1,32'h8000_0408,1,32'h8000_0404,32'h2402_0002));
    vecs.push_back(v(0,1,0,2'b00,0,0,32'h0,0,1,32'h4444_4444,        0,32'h8000_0408,1,32'h8000_0404,32'h2402_0002));
    vecs.push_back(v(0,0,0,2'b10,0,0,32'h8000_0800,0,0,32'h0,        0,32'h8000_0408,1,32'h8000_0404,32'h2402_0002));
    vecs.push_back(v(0,0,0,2'b00,0,0,32'h0,0,0,32'h0,                1,32'h8000_0800,0,32'h8000_0404,32'h0));

    applyStimulus(vecs[0]);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Reset asserted while a request is being presented must hide it at once
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("req_masked_in_reset", {31'h0, inst_bus.inst_req}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("req_after_reset", {31'h0, inst_bus.inst_req}, 32'h1);
    checkOutput("addr_after_reset", inst_bus.inst_addr, 32'h8000_0000);
    checkOutput("valid_after_reset", {31'h0, ID_Valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It sits directly upstream of the hazard unit and the decode stage. It issues requests on the SRAM-like instruction bus, with one request outstanding at most, and latches the returned word into IF/ID. It obeys `Stall` and `IF_Flush` from the hazard unit and redirects fetch on taken branches and jumps resolved in ID. There are no delay slots: the instruction fetched behind a taken transfer is squashed.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `Stall` in 1: freeze IF/ID and suppress redirect.
- `IF_Flush` in 1: load a bubble into IF/ID at this edge.
- `ID_PCSrc` in 2: 00 sequential, 01 j/jal, 10/11 jr/jalr.
- `ID_Branch`, `ID_Zero` in 1 each: a conditional branch is taken when both are 1.
- `ID_RegData` in 32: forwarded rs value, used as the jr/jalr target.
- `inst_req` out 1, `inst_addr` out 32: request and its address.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1, `inst_rdata` in 32: response returned this cycle.
- `ID_Valid` out 1, `ID_PC` out 32, `ID_Instruction` out 32: IF/ID register contents.

## Operation
- redirect = `ID_Valid` & ~`Stall` & ((`ID_PCSrc`≠00) | (`ID_Branch` & `ID_Zero`)).
- Target selection:
  - `ID_PCSrc`=01: {(`ID_PC`+4)[31:28], `ID_Instruction`[25:0], 2'b00}.
  - `ID_PCSrc`=1x: `ID_RegData`.
  - Otherwise: `ID_PC`+4+(sign-extended `ID_Instruction`[15:0]<<2).
  - `ID_PCSrc` has priority over branch.
- No alignment check is made. All address arithmetic is mod 2^32, so 0xFFFF_FFFC+4 = 0.
- State `fetch_pc` holds the address being fetched.
- FSM states: REQ, WAIT, HOLD, CANCEL.
  - **REQ**: `inst_req`=1, `inst_addr`=`fetch_pc`.
    - `addr_ok` → WAIT.
    - redirect without `addr_ok` → `fetch_pc`<=target, stay REQ. The address may change before acceptance.
    - redirect with `addr_ok` → `fetch_pc`<=target, go to CANCEL.
  - **WAIT**: `inst_req`=0.
    - `data_ok` & redirect → drop data, `fetch_pc`<=target, go to REQ.
    - `data_ok` & `Stall` → capture `rdata` into the hold buffer, go to HOLD.
    - `data_ok` otherwise → IF/ID<={1,`fetch_pc`,`rdata`}, `fetch_pc`+=4, go to REQ.
    - redirect without `data_ok` → `fetch_pc`<=target, go to CANCEL.
  - **HOLD**: `inst_req`=0.
    - redirect → drop the hold buffer, `fetch_pc`<=target, go to REQ.
    - ~`Stall` → IF/ID<=hold, `fetch_pc`+=4, go to REQ.
  - **CANCEL**: `inst_req`=0. Wait for `data_ok`, discard the response, go to REQ. A redirect here updates `fetch_pc` only.
- IF/ID update priority, highest first:
  1. `reset`.
  2. `Stall`: hold the register.
  3. `IF_Flush` or redirect: bubble.
  4. Fresh word delivered: load it.
  5. Otherwise: bubble.
- A bubble is `ID_Valid`=0 and `ID_Instruction`=0 (nop). `ID_PC` keeps its value.

## Timing
- Reset values:
  - FSM=REQ, `fetch_pc`=`RESET_PC`.
  - `ID_Valid`=0, `ID_PC`=0, `ID_Instruction`=0.
  - `inst_req` is forced to 0 while `reset`=1.
- Reset mid-transaction abandons any outstanding request. The bus is required to drop it as well.
- Latency with zero-wait memory:
  - Cycle 0: request accepted.
  - Cycle 1: `data_ok`.
  - Cycle 2: `ID_Valid`=1 and the next request goes out.
  - Throughput is one instruction per 2 cycles.
- Redirect takes effect on the edge ending the cycle in which `ID_Valid`=1. The new address appears on `inst_addr` the following cycle, unless a cancelled response is still pending.
- `inst_rdata` is sampled only when `data_ok`=1.
- Simultaneous `Stall` and redirect cannot occur, because redirect is gated by ~`Stall`.
- Responses are in order, with one outstanding request at most.

## Structure
- Shared `mips_pkg` holds:
  - `PCSRC_SEQ`/`PCSRC_J`/`PCSRC_JR` encodings.
  - `NOP`=32'h0.
  - Default `RESET_PC`.
  - FSM state enum.
- One combinational sub-module, `next_pc_gen`, takes (`ID_PC`, `ID_Instruction`, `ID_PCSrc`, `ID_Branch`, `ID_Zero`, `ID_RegData`) and produces (redirect_raw, target). Gating with `ID_Valid` and ~`Stall` is done in `fetch_unit`.

## Test plan
- **Reset release, zero-wait memory.** `inst_addr` sequence is 0x8000_0000, 0x8000_0004. `ID_PC` shows 0x8000_0000 with `ID_Valid`=1 in cycle 2.
- **Stall during WAIT.** Stall for 3 cycles while `data_ok` returns 0x2402_0005 → FSM goes to HOLD. The word enters IF/ID on the first non-stall edge. No re-request and no lost word.
- **Taken beq in ID.** `ID_PC`=0x8000_0010, imm=0xFFFF → next `inst_addr`=0x8000_0010. The in-flight word is discarded via CANCEL and IF/ID receives a bubble.
- **jr with redirect coincident with `addr_ok`.** `ID_RegData`=0x8000_0200 → the old response is discarded and the next request goes to 0x8000_0200.
- **Jump near the top of the address space.** j at 0xFFFF_FFFC → target uses bits [31:28] of 0x0000_0000 (wrapped PC+4).
- **Reset asserted in WAIT.** `inst_req`=0 during reset. Afterwards refetch starts from `RESET_PC` with `ID_Valid`=0.
